tamagotchi_need_engine: RTL
===========================

// Module: tamagotchi_need_engine
// PURPOSE
//  Parametrised successor of the pet-state FSM: N independent need channels (health, energy, food, fun, ...),
//  each a saturating level with its own decay and refill timing. Arbitrates refill requests, tracks the
//  shown channel, drives happy/sad face bit and 7-seg digit. Adds normal/test modes, tick prescaler, hold-to-refill.
// PARAMETERS
//  N_NEEDS      4        number of need channels (1..8)
//  LEVEL_W      4        level counter width
//  LEVEL_MIN    1        floor level; LEVEL_MAX 10 ceiling; LEVEL_INIT 8 level after reset
//  HAPPY_TH     5        happy when shown level >= HAPPY_TH
//  TICK_DIV     7500000  clk cycles per tick (1 in simulation)
//  DECAY_TICKS  24       ticks between decrements of an idle channel
//  HOLD_TICKS   6        ticks a request must be held per +1 refill step
// PORTS
//  clk          in   1                  system clock
//  btn_reset    in   1                  synchronous active-high reset
//  btn_test     in   1                  enter test mode (level-sensitive)
//  req          in   N_NEEDS            refill request per channel, active-high, level-sensitive
//  sel_idx      out  SW=max(1,clog2 N)  channel currently shown
//  level_out    out  LEVEL_W            level of shown channel
//  happy        out  1                  shown level >= HAPPY_TH
//  seg_display  out  7                  active-low 7-seg code of level_out (0-9, A=10, blank otherwise)
//  levels       out  N_NEEDS*LEVEL_W    all levels, channel i at [i*LEVEL_W +: LEVEL_W]
//  test_mode    out  1                  1 = test mode active
//  alarm        out  1                  see CONFIGURATION
// BEHAVIOUR
//  Reset (clk edge with btn_reset=1, overrides all): levels=LEVEL_INIT, all timers/prescaler 0, sel_idx=0,
//   test_mode=0, alarm=0; level_out/happy/seg_display reflect channel 0 one cycle later (registered outputs).
//  Tick: prescaler counts 0..TICK_DIV-1; tick=1 for one clk when it wraps. All timers advance only on tick.
//  Arbitration: lowest-index asserted req bit wins (winner w). No req -> no refill, sel_idx holds.
//  Selection FSM (NORMAL mode): IDLE -> SHOW when any req (sel_idx<=w, hold timer cleared);
//   SHOW -> HOLD next cycle if req[w] still high and w==sel_idx, else IDLE;
//   HOLD: on each tick hold timer++; at HOLD_TICKS: level[w]+1 if < LEVEL_MAX (saturate), hold timer=0,
//   decay timer[w]=0; winner changes -> SHOW with new w; req released -> IDLE (partial hold discarded).
//  Decay (NORMAL): every channel not in HOLD has decay timer++ on tick; at DECAY_TICKS: level-1 if > LEVEL_MIN,
//   timer=0. Channel at LEVEL_MIN keeps timer at 0. Refill and decay same tick on same channel: refill wins.
//  Test mode: btn_test=1 -> test_mode=1 next cycle, FSM to IDLE, decay frozen, timers cleared.
//   Rising edge of req[i] (registered previous value): sel_idx<=i; level[i] toggles: LEVEL_MIN->LEVEL_MAX,
//   any other->LEVEL_MIN. Multiple rising edges same cycle: all toggle, sel_idx=lowest. Exit only via btn_reset.
//  btn_reset and btn_test same cycle: reset wins, test_mode=0.
//  Outputs: level_out=levels[sel_idx], happy, seg_display all registered, 1-cycle latency after level/sel update.
//  Arithmetic: levels never leave [LEVEL_MIN,LEVEL_MAX]; timers sized clog2(max(DECAY_TICKS,HOLD_TICKS)+1).
// CONFIGURATION
//  CRITICAL_ALARM_EN defined: alarm=1 (registered) while any channel in NORMAL mode sits at LEVEL_MIN;
//   sel_idx auto-jumps to lowest critical channel when FSM is IDLE; forced 0 in test mode.
//  Not defined: alarm tied 0, no auto-jump, no critical-detect logic synthesised.
// TESTING (TICK_DIV=1, defaults otherwise)
//  Reset, no req, 25 ticks -> all levels 7, seg_display=7'b1111000, happy=1.
//  Hold req=4'b0001 for 1+1+6 ticks -> sel_idx=0, level0 8->9; hold 18 more ticks -> level0 saturates at 10.
//  req=4'b0110 held -> sel_idx=1, only channel 1 refills; channel 2 decays every 24 ticks.
//  No req for 7*24 ticks -> all levels 1 and stay 1; with CRITICAL_ALARM_EN alarm=1, sel_idx=0; else alarm=0.
//  btn_test then pulse req[3] twice -> level3 1 then 10 (from 8: ->1, ->10); seg_display=7'b0001000; no decay.
//  btn_reset mid-HOLD on channel 2 -> next cycle levels all 8, test_mode=0, sel_idx=0, hold progress lost.

Source files
------------

// File: rtl/tamagotchi_need_engine_if.sv
// Bus bundle for tamagotchi_need_engine: refill requests in, display/status out.
//   req          refill request per channel (level-sensitive, active-high)
//   sel_idx      channel currently shown
//   level_out    level of the shown channel (registered)
//   happy        shown level >= happy threshold (registered)
//   seg_display  active-low 7-seg code of level_out, gfedcba order (registered)
//   levels       all channel levels, channel i at [i*LEVEL_W +: LEVEL_W]
//   test_mode    1 while test mode is active
//   alarm        critical-level alarm (0 unless CRITICAL_ALARM_EN is defined)
// Modports: master = stimulus side, slave = engine side.
interface tamagotchi_need_engine_if #(
  parameter int N_NEEDS = 4,
  parameter int LEVEL_W = 4
);
  localparam int SW = (N_NEEDS > 1) ? $clog2(N_NEEDS) : 1;

  logic [N_NEEDS-1:0]         req;
  logic [SW-1:0]              sel_idx;
  logic [LEVEL_W-1:0]         level_out;
  logic                       happy;
  logic [6:0]                 seg_display;
  logic [N_NEEDS*LEVEL_W-1:0] levels;
  logic                       test_mode;
  logic                       alarm;

  modport master (
    output req,
    input  sel_idx, level_out, happy, seg_display, levels, test_mode, alarm
  );

  modport slave (
    input  req,
    output sel_idx, level_out, happy, seg_display, levels, test_mode, alarm
  );
endinterface

// File: rtl/tamagotchi_need_engine.sv
// tamagotchi_need_engine: N saturating need channels with per-channel decay,
// hold-to-refill arbitration (lowest index wins), shown-channel selection,
// happy bit and 7-seg digit of the shown level. Test mode toggles levels on
// request rising edges.
// Ports:
//   clk        system clock
//   btn_reset  synchronous active-high reset, overrides everything
//   btn_test   enter test mode (level-sensitive, sticky until reset)
//   bus        tamagotchi_need_engine_if.slave (req in, display/status out)
// Optional feature macro: CRITICAL_ALARM_EN
//   defined   -> registered alarm while any channel sits at LEVEL_MIN in normal
//                mode, and sel_idx auto-jumps to the lowest critical channel
//                while the selection FSM is idle
//   undefined -> alarm tied low, no critical-detect logic
module tamagotchi_need_engine #(
  parameter int N_NEEDS     = 4,
  parameter int LEVEL_W     = 4,
  parameter int LEVEL_MIN   = 1,
  parameter int LEVEL_MAX   = 10,
  parameter int LEVEL_INIT  = 8,
  parameter int HAPPY_TH    = 5,
  parameter int TICK_DIV    = 7500000,
  parameter int DECAY_TICKS = 24,
  parameter int HOLD_TICKS  = 6
) (
  input  logic                      clk,
  input  logic                      btn_reset,
  input  logic                      btn_test,
  tamagotchi_need_engine_if.slave   bus
);

  localparam int SW   = (N_NEEDS > 1) ? $clog2(N_NEEDS) : 1;
  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMAX = (DECAY_TICKS > HOLD_TICKS) ? DECAY_TICKS : HOLD_TICKS;
  localparam int TW   = $clog2(TMAX + 1);

  typedef logic [LEVEL_W-1:0] level_t;
  typedef logic [TW-1:0]      timer_t;
  typedef logic [SW-1:0]      sel_t;
  typedef enum logic [1:0] {IDLE, SHOW, HOLD} state_t;

  localparam level_t L_MIN   = LEVEL_W'(LEVEL_MIN);
  localparam level_t L_MAX   = LEVEL_W'(LEVEL_MAX);
  localparam level_t L_INIT  = LEVEL_W'(LEVEL_INIT);
  localparam level_t L_HAPPY = LEVEL_W'(HAPPY_TH);
  localparam timer_t DEC_END = TW'(DECAY_TICKS - 1);
  localparam timer_t HLD_END = TW'(HOLD_TICKS - 1);

  function automatic logic [6:0] seg7(level_t v);
    case (int'(v))
      0:       seg7 = 7'b1000000;
      1:       seg7 = 7'b1111001;
      2:       seg7 = 7'b0100100;
      3:       seg7 = 7'b0110000;
      4:       seg7 = 7'b0011001;
      5:       seg7 = 7'b0010010;
      6:       seg7 = 7'b0000010;
      7:       seg7 = 7'b1111000;
      8:       seg7 = 7'b0000000;
      9:       seg7 = 7'b0010000;
      10:      seg7 = 7'b0001000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  logic [PW-1:0]      presc_q, presc_d;
  state_t             state_q, state_d;
  sel_t               sel_q, sel_d;
  timer_t             hold_q, hold_d;
  logic               test_q, test_d;
  logic [N_NEEDS-1:0] req_prev_q, req_prev_d;
  level_t             lvl_q [N_NEEDS];
  level_t             lvl_d [N_NEEDS];
  timer_t             dec_q [N_NEEDS];
  timer_t             dec_d [N_NEEDS];
  level_t             lout_q, lout_d;
  logic               happy_q, happy_d;
  logic [6:0]         seg_q, seg_d;

  logic               tick;
  logic               any_req;
  sel_t               win;
  logic               edge_found;
  logic [N_NEEDS*LEVEL_W-1:0] levels_flat;

`ifdef CRITICAL_ALARM_EN
  logic any_crit;
  sel_t crit_idx;
  logic alarm_q, alarm_d;

  always_comb begin
    any_crit = 1'b0;
    crit_idx = '0;
    for (int unsigned i = 0; i < N_NEEDS; i++) begin
      if (lvl_q[i] == L_MIN && !any_crit) begin
        any_crit = 1'b1;
        crit_idx = SW'(i);
      end
    end
  end
`endif

  // Lowest-index asserted request wins.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    for (int unsigned i = 0; i < N_NEEDS; i++) begin
      if (bus.req[i] && !any_req) begin
        any_req = 1'b1;
        win     = SW'(i);
      end
    end
  end

  always_comb begin
    presc_d    = presc_q;
    state_d    = state_q;
    sel_d      = sel_q;
    hold_d     = hold_q;
    test_d     = test_q;
    req_prev_d = bus.req;
    lvl_d      = lvl_q;
    dec_d      = dec_q;
    edge_found = 1'b0;

    tick    = (presc_q == PW'(TICK_DIV - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;

    if (test_q || btn_test) begin
      // Entering or in test mode: FSM parked, decay frozen, timers cleared.
      // Toggling only starts once test mode is registered.
      test_d  = 1'b1;
      state_d = IDLE;
      hold_d  = '0;
      for (int unsigned i = 0; i < N_NEEDS; i++) begin
        dec_d[i] = '0;
      end
      if (test_q) begin
        for (int unsigned i = 0; i < N_NEEDS; i++) begin
          if (bus.req[i] && !req_prev_q[i]) begin
            lvl_d[i] = (lvl_q[i] == L_MIN) ? L_MAX : L_MIN;
            if (!edge_found) begin
              edge_found = 1'b1;
              sel_d      = SW'(i);
            end
          end
        end
      end
    end else begin
      // Decay for every channel not currently being held.
      if (tick) begin
        for (int unsigned i = 0; i < N_NEEDS; i++) begin
          if (!(state_q == HOLD && SW'(i) == sel_q)) begin
            if (lvl_q[i] == L_MIN) begin
              dec_d[i] = '0;
            end else if (dec_q[i] == DEC_END) begin
              lvl_d[i] = lvl_q[i] - 1'b1;
              dec_d[i] = '0;
            end else begin
              dec_d[i] = dec_q[i] + 1'b1;
            end
          end
        end
      end

      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_d = SHOW;
            sel_d   = win;
            hold_d  = '0;
          end
`ifdef CRITICAL_ALARM_EN
          else if (any_crit) begin
            sel_d = crit_idx;
          end
`endif
        end
        SHOW: begin
          state_d = (any_req && win == sel_q) ? HOLD : IDLE;
        end
        HOLD: begin
          if (!any_req) begin
            state_d = IDLE;
            hold_d  = '0;
          end else if (win != sel_q) begin
            state_d = SHOW;
            sel_d   = win;
            hold_d  = '0;
          end else if (tick) begin
            if (hold_q == HLD_END) begin
              hold_d       = '0;
              dec_d[sel_q] = '0;
              if (lvl_q[sel_q] < L_MAX) begin
                lvl_d[sel_q] = lvl_q[sel_q] + 1'b1;
              end
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    lout_d  = lvl_q[sel_q];
    happy_d = (lout_d >= L_HAPPY);
    seg_d   = seg7(lout_d);

`ifdef CRITICAL_ALARM_EN
    alarm_d = any_crit && !test_d;
`endif
  end

  always_comb begin
    levels_flat = '0;
    for (int unsigned i = 0; i < N_NEEDS; i++) begin
      levels_flat[i*LEVEL_W +: LEVEL_W] = lvl_q[i];
    end
  end

  always_ff @(posedge clk) begin
    // Previous-request register only feeds edge detection; no reset needed.
    req_prev_q <= req_prev_d;
    if (btn_reset) begin
      presc_q <= '0;
      state_q <= IDLE;
      sel_q   <= '0;
      hold_q  <= '0;
      test_q  <= 1'b0;
      for (int unsigned i = 0; i < N_NEEDS; i++) begin
        lvl_q[i] <= L_INIT;
        dec_q[i] <= '0;
      end
      lout_q  <= '0;
      happy_q <= 1'b0;
      seg_q   <= '1;
`ifdef CRITICAL_ALARM_EN
      alarm_q <= 1'b0;
`endif
    end else begin
      presc_q <= presc_d;
      state_q <= state_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      test_q  <= test_d;
      lvl_q   <= lvl_d;
      dec_q   <= dec_d;
      lout_q  <= lout_d;
      happy_q <= happy_d;
      seg_q   <= seg_d;
`ifdef CRITICAL_ALARM_EN
      alarm_q <= alarm_d;
`endif
    end
  end

  assign bus.sel_idx     = sel_q;
  assign bus.level_out   = lout_q;
  assign bus.happy       = happy_q;
  assign bus.seg_display = seg_q;
  assign bus.levels      = levels_flat;
  assign bus.test_mode   = test_q;
`ifdef CRITICAL_ALARM_EN
  assign bus.alarm       = alarm_q;
`else
  assign bus.alarm       = 1'b0;
`endif

endmodule
